// File: rtl/qupls_alu_sched.sv
// Round-robin ALU issue scheduler with writeback-port reservation and optional divider occupancy tracking.
// Optional divide scheduling is enabled by defining QUPLS_ALU_SCHED_DIV_EN.
module qupls_alu_sched #(
  parameter int NREQ    = 8,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   kind,
  input  logic                stall,
  output logic [NREQ-1:0]     gnt,
  output logic                gnt_v,
  output logic [1:0]          gnt_kind,
  output logic                wb_v,
  output logic                div_busy
);

`ifdef QUPLS_ALU_SCHED_DIV_EN
  localparam int RW = DIV_LAT;
`else
  localparam int RW = MUL_LAT;
`endif
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (!(DIV_LAT > MUL_LAT && MUL_LAT > 1)) begin : g_bad_lat
    $error("qupls_alu_sched: latencies must satisfy DIV_LAT > MUL_LAT > 1");
  end

  logic [PW-1:0]   rr;
  logic [RW:1]     resv;
  logic [RW:1]     resv_sh;
  logic [RW:1]     resv_nxt;
  logic [NREQ-1:0] elig;
  logic            win;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [1:0]      win_kind;

`ifdef QUPLS_ALU_SCHED_DIV_EN
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [CW-1:0] div_cnt;
  assign div_busy = (div_cnt != '0);
`else
  assign div_busy = 1'b0;
`endif

  // NOTE: every signal written here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // Eligibility looks at the reservation vector as it will be after this cycle's shift.
    resv_sh = resv >> 1;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = 1'b0;
      if (req[i] && !gnt[i] && !stall) begin
        case (kind[2*i +: 2])
          2'b00:   elig[i] = !resv_sh[1];
          2'b01:   elig[i] = !resv_sh[MUL_LAT];
`ifdef QUPLS_ALU_SCHED_DIV_EN
          2'b10:   elig[i] = !div_busy && !resv_sh[DIV_LAT];
`endif
          default: elig[i] = 1'b0;
        endcase
      end
    end

    // Scan downward so the last hit is the first eligible entry at or after rr.
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = PW'((int'(rr) + off) % NREQ);
      if (elig[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end

    win_kind = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (win && (i == int'(win_idx))) win_kind = kind[2*i +: 2];
    end

    resv_nxt = resv_sh;
    if (win) begin
      case (win_kind)
        2'b00:   resv_nxt[1]       = 1'b1;
        2'b01:   resv_nxt[MUL_LAT] = 1'b1;
`ifdef QUPLS_ALU_SCHED_DIV_EN
        2'b10:   resv_nxt[DIV_LAT] = 1'b1;
`endif
        default: resv_nxt = resv_sh;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      gnt_v    <= 1'b0;
      gnt_kind <= 2'b00;
      rr       <= '0;
      resv     <= '0;
      wb_v     <= 1'b0;
    end else begin
      gnt      <= win ? (NREQ'(1) << win_idx) : '0;
      gnt_v    <= win;
      gnt_kind <= win ? win_kind : 2'b00;
      if (win) rr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      resv     <= resv_nxt;
      wb_v     <= resv[1];
    end
  end

`ifdef QUPLS_ALU_SCHED_DIV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (win && win_kind == 2'b10) begin
      div_cnt <= CW'(DIV_LAT);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qupls_alu_sched.sv
// Randomized bench for qupls_alu_sched against an absolute-time booking model of the writeback port.
module tb_qupls_alu_sched;
  localparam int NREQ    = 8;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 20;
`ifdef QUPLS_ALU_SCHED_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] kind;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic              gnt_v;
  logic [1:0]        gnt_kind;
  logic              wb_v;
  logic              div_busy;

  always #5 clk = ~clk;

  qupls_alu_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .kind(kind), .stall(stall),
    .gnt(gnt), .gnt_v(gnt_v), .gnt_kind(gnt_kind), .wb_v(wb_v), .div_busy(div_busy)
  );

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  // Model state: booked holds absolute cycles in which the writeback port is taken.
  bit         booked[int];
  int         rr_m     = 0;
  int         prev_m   = -1;
  int         div_free = 0;
  int         exp_idx;
  logic [1:0] exp_kind;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cur_k, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] k);
    return (k == 2'b00) ? 1 : (k == 2'b01) ? MUL_LAT : DIV_LAT;
  endfunction

  function automatic bit legal(input logic [1:0] k);
    return (k == 2'b00) || (k == 2'b01) || (k == 2'b10 && DIV_EN);
  endfunction

  // Decide the grant for arbitration cycle k; a grant with latency L takes the port at k+L+1.
  task automatic model_step(input int k);
    logic [1:0] kd;
    exp_idx  = -1;
    exp_kind = 2'b00;
    if (rst) begin
      booked.delete();
      rr_m     = 0;
      prev_m   = -1;
      div_free = 0;
      return;
    end
    if (!stall) begin
      for (int off = 0; off < NREQ; off++) begin
        int i;
        i  = (rr_m + off) % NREQ;
        kd = kind[2*i +: 2];
        if (req[i] && i != prev_m && legal(kd) && !booked.exists(k + lat_of(kd) + 1) &&
            (kd != 2'b10 || k >= div_free)) begin
          exp_idx  = i;
          exp_kind = kd;
          break;
        end
      end
    end
    prev_m = exp_idx;
    if (exp_idx >= 0) begin
      booked[k + lat_of(exp_kind) + 1] = 1'b1;
      rr_m = (exp_idx + 1) % NREQ;
      if (exp_kind == 2'b10) div_free = k + DIV_LAT + 1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    kind  = '0;
    stall = 1'b0;
    for (int k = 0; k < 1700; k++) begin
      cur_k = k;
      rst   = (k < 3) || (k == 900) || (k == 901);
      stall = 1'b0;
      if (k >= 3 && k < 40) begin
        req  = '1;
        kind = '0;
      end else if (k >= 40 && k < 60) begin
        req   = 8'h0F;
        kind  = '0;
        stall = (k >= 45 && k < 48);
      end else if (k == 60) begin
        req  = 8'h0C;
        kind = 16'h00A0;
      end else if (k == 130) begin
        req  = 8'h01;
        kind = 16'h0001;
      end else if (k > 130 && k < 160) begin
        if (k >= 130 + MUL_LAT - 1 && k < 140) req[1] = 1'b1;
      end else if (k >= 160) begin
        stall = ($urandom % 8) == 0;
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i]) begin
            if ($urandom % 3 == 0) begin
              req[i]        = 1'b1;
              kind[2*i +: 2] = 2'($urandom % 4);
            end
          end else if (!legal(kind[2*i +: 2]) && ($urandom % 4 == 0)) begin
            req[i] = 1'b0;
          end
        end
      end
      model_step(k);
      @(posedge clk);
      #1;
      check("gnt", 32'(gnt), (exp_idx >= 0) ? (32'd1 << exp_idx) : 32'd0);
      check("gnt_v", 32'(gnt_v), 32'(exp_idx >= 0));
      check("gnt_kind", 32'(gnt_kind), 32'(exp_kind));
      check("wb_v", 32'(wb_v), 32'(booked.exists(k + 1)));
      check("div_busy", 32'(div_busy), 32'(DIV_EN && (k + 1) < div_free));
      if (exp_idx >= 0) req[exp_idx] = 1'b0;
      if (k == 130 || (k > 130 && k < 160 && exp_idx == 1)) kind[3:2] = 2'b00;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qupls_alu_sched.md
QUPLS_ALU_SCHED -- requirements
Module: qupls_alu_sched

Interface
REQ-001 SHALL have parameter NREQ, default 8, number of ALU-class requesters (reservation entries).
REQ-002 SHALL have parameter MUL_LAT, default 3, multiply issue-to-writeback latency in cycles.
REQ-003 SHALL have parameter DIV_LAT, default 20, divide issue-to-writeback latency in cycles; DIV_LAT > MUL_LAT > 1.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  NREQ  per-entry request, held until granted.
REQ-007 SHALL have port kind  input  2*NREQ  per-entry op class: 00 simple, 01 mul, 10 div, 11 reserved (never granted).
REQ-008 SHALL have port stall  input  1  downstream ALU cannot accept an issue this cycle.
REQ-009 SHALL have port gnt  output  NREQ  registered one-hot grant (all zero when none).
REQ-010 SHALL have port gnt_v  output  1  registered, high when gnt is non-zero.
REQ-011 SHALL have port gnt_kind  output  2  registered class of granted entry.
REQ-012 SHALL have port wb_v  output  1  high in cycles where a scheduled result occupies the shared writeback port.
REQ-013 SHALL have port div_busy  output  1  high while the non-pipelined divider is occupied.

Function
REQ-014 Arbitration SHALL evaluate req/kind each cycle; the winner's grant appears on gnt in the following cycle (1-cycle latency).
REQ-015 Arbitration SHALL be round-robin starting at pointer rr; after a grant to index i, rr SHALL become (i+1) mod NREQ; rr unchanged with no grant.
REQ-016 An entry granted in the previous cycle SHALL be masked from the current arbitration (no double grant while requester drops req).
REQ-017 Latency L per class: simple 1, mul MUL_LAT, div DIV_LAT.
REQ-018 Writeback reservation vector resv[DIV_LAT:1] SHALL track port occupancy; bit k = port busy k cycles after current cycle; it SHALL shift down one position every cycle regardless of stall.
REQ-019 An entry SHALL be eligible only if req high, kind legal, and resv[L] (post-shift) clear; granting SHALL set resv[L].
REQ-020 A div entry SHALL additionally require div_busy low; a div grant SHALL load a counter with DIV_LAT, decrementing each cycle; div_busy high while counter non-zero.
REQ-021 While stall high, no grant SHALL be issued, gnt/gnt_v SHALL be 0 next cycle, rr and div counter behave as if no grant.
REQ-022 Ineligible entries SHALL be skipped; arbitration picks the first eligible entry at or after rr (wrap-around to index 0 after NREQ-1).
REQ-023 wb_v SHALL equal resv[1] before shift, i.e. high exactly L cycles after the cycle gnt_v was high for that grant.
REQ-024 At most one grant per cycle; no two scheduled results SHALL ever share a writeback cycle.

Reset
REQ-025 On rst: gnt=0, gnt_v=0, gnt_kind=00, resv=0, wb_v=0, rr=0, div counter=0, div_busy=0, previous-grant mask=0.
REQ-026 rst mid-operation SHALL discard all in-flight reservations and divider occupancy; first grant possible in the cycle after rst deasserts, appearing on gnt one cycle later.

Configuration
REQ-027 Macro QUPLS_ALU_SCHED_DIV_EN defined: divide scheduling per REQ-020.
REQ-028 Macro undefined: kind 10 treated as reserved (never granted), div counter removed, div_busy tied 0, resv width reduced to MUL_LAT.

Verification
REQ-029 Reset then req=8'h01 kind0=00 -> gnt=8'h01 gnt_v=1 one cycle later, wb_v high one cycle after that, rr=1.
REQ-030 req=8'hFF all simple, held -> grants rotate 01,02,04,...,80,01 over successive cycles, never repeating an entry consecutively.
REQ-031 Entry0 mul granted cycle t, entry1 simple requesting from t+MUL_LAT-2 -> entry1 not granted for slot colliding at t+MUL_LAT; wb_v never indicates double booking.
REQ-032 (DIV_EN) entries 2 and 3 both div -> entry2 granted, div_busy high 20 cycles, entry3 granted only once div_busy low; without macro neither granted.
REQ-033 stall high 3 cycles with req=8'h0F -> gnt_v=0 those cycles+1, rr unchanged, first grant after stall to rr index.
REQ-034 rst asserted while div and mul in flight -> next cycle resv=0, div_busy=0, wb_v=0, new div grantable immediately.
